// File: rtl/mem_db_ctrl.sv
// Ping-pong controller for the mem_db double-buffered RAM. It fills the write bank from a
// valid/ready stream, swaps banks per tile and drains the read bank through a 2-entry skid FIFO.
module mem_db_ctrl #(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 1024,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int TILE_LEN = DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data,
    output logic                out_last,
    output logic                mem_sw,
    output logic [ADDR_BIT-1:0] mem_waddr,
    output logic                mem_wen,
    output logic [DATA_BIT-1:0] mem_wdata,
    output logic [ADDR_BIT-1:0] mem_raddr,
    output logic                mem_ren,
    input  logic [DATA_BIT-1:0] mem_rdata
);

    localparam logic [ADDR_BIT-1:0] LAST_IDX = ADDR_BIT'(TILE_LEN - 1);

    logic                r_sw;
    logic [ADDR_BIT-1:0] r_wcnt;
    logic [ADDR_BIT-1:0] r_rcnt;
    logic                r_wr_full;
    logic                r_rd_busy;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [1:0]          r_skid_cnt;
    logic [1:0]          r_skid_last;
    logic [DATA_BIT-1:0] r_skid_data [2];

    logic                w_wr_acc;
    logic                w_wr_last;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_ren;
    logic                w_last_ren;
    logic                w_swap;
    logic [1:0]          w_nxt_cnt;
    logic [1:0]          w_nxt_last;
    logic [DATA_BIT-1:0] w_nxt_data [2];

    assign w_wr_acc   = in_valid & ~r_wr_full;
    assign w_wr_last  = w_wr_acc & (r_wcnt == LAST_IDX);
    assign w_pop      = (r_skid_cnt != 2'd0) & out_ready;

    // Words already owed to the FIFO (buffered + in flight) after this cycle's pop; keeping
    // this below 2 before issuing guarantees the skid FIFO can never overflow.
    assign w_occ      = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_ren      = r_rd_busy & (w_occ < 3'd2);
    assign w_last_ren = w_ren & (r_rcnt == LAST_IDX);

    // A swap on the final read of the old bank is safe: this cycle's read still uses the old sw.
    assign w_swap     = r_wr_full & (~r_rd_busy | w_last_ren);

    assign in_ready   = ~r_wr_full;
    assign mem_wen    = w_wr_acc;
    assign mem_waddr  = r_wcnt;
    assign mem_wdata  = in_data;
    assign mem_ren    = w_ren;
    assign mem_raddr  = r_rcnt;
    assign mem_sw     = r_sw;
    assign out_valid  = (r_skid_cnt != 2'd0);
    assign out_data   = r_skid_data[0];
    assign out_last   = out_valid & r_skid_last[0];

    // NOTE: every variable gets a default at the top of the block so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_nxt_data = r_skid_data;
        w_nxt_last = r_skid_last;
        w_nxt_cnt  = r_skid_cnt;
        if (w_pop) begin
            w_nxt_data[0] = r_skid_data[1];
            w_nxt_last[0] = r_skid_last[1];
            w_nxt_cnt     = r_skid_cnt - 2'd1;
        end
        if (r_inflight) begin
            w_nxt_data[w_nxt_cnt[0]] = mem_rdata;
            w_nxt_last[w_nxt_cnt[0]] = r_inflight_last;
            w_nxt_cnt                = w_nxt_cnt + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw            <= 1'b0;
            r_wcnt          <= '0;
            r_rcnt          <= '0;
            r_wr_full       <= 1'b0;
            r_rd_busy       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_skid_cnt      <= 2'd0;
            r_skid_last     <= 2'b00;
        end else begin
            if (w_wr_acc) begin
                r_wcnt <= w_wr_last ? '0 : r_wcnt + ADDR_BIT'(1);
            end
            if (w_ren) begin
                r_rcnt <= w_last_ren ? '0 : r_rcnt + ADDR_BIT'(1);
            end

            if (w_swap) begin
                r_sw      <= ~r_sw;
                r_wr_full <= 1'b0;
                r_rd_busy <= 1'b1;
            end else begin
                if (w_wr_last) begin
                    r_wr_full <= 1'b1;
                end
                if (w_last_ren) begin
                    r_rd_busy <= 1'b0;
                end
            end

            r_inflight      <= w_ren;
            r_inflight_last <= w_last_ren;
            r_skid_cnt      <= w_nxt_cnt;
            r_skid_last     <= w_nxt_last;
        end
    end

    // NOTE: the FIFO payload is not reset; the occupancy count alone decides validity,
    // so clearing wide data registers would buy nothing.
    always_ff @(posedge clk) begin
        r_skid_data <= w_nxt_data;
    end

endmodule

// File: tb/tb_mem_db_ctrl.sv
// Self-checking bench for mem_db_ctrl: a behavioural mem_db model, a stream scoreboard and
// per-cycle protocol checks, with literal timing pins for the single-tile case.
module tb_mem_db_ctrl;

    localparam int DW    = 16;
    localparam int TILE  = 8;
    localparam int TILE5 = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          mem_sw;
    logic [2:0]    mem_waddr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_raddr;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;

    logic          rst5;
    logic          in_valid5;
    logic          in_ready5;
    logic [DW-1:0] in_data5;
    logic          out_valid5;
    logic          out_ready5;
    logic [DW-1:0] out_data5;
    logic          out_last5;
    logic          mem_sw5;
    logic [2:0]    mem_waddr5;
    logic          mem_wen5;
    logic [DW-1:0] mem_wdata5;
    logic [2:0]    mem_raddr5;
    logic          mem_ren5;
    logic [DW-1:0] mem_rdata5;

    assign out_ready5 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int out_mode = 1;  // 0: hold low, 1: hold high, 2: random
    logic done5 = 1'b0;

    mem_db_ctrl #(.DATA_BIT(DW), .DEPTH(8), .TILE_LEN(TILE)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mem_sw(mem_sw), .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
    );

    mem_db_ctrl #(.DATA_BIT(DW), .DEPTH(8), .TILE_LEN(TILE5)) u_dut5 (
        .clk(clk), .rst(rst5),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_last(out_last5),
        .mem_sw(mem_sw5), .mem_waddr(mem_waddr5), .mem_wen(mem_wen5), .mem_wdata(mem_wdata5),
        .mem_raddr(mem_raddr5), .mem_ren(mem_ren5), .mem_rdata(mem_rdata5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mem_db model: sw=0 writes bank1 and reads bank0; read data is registered.
    logic [DW-1:0] mem_a [2][8];
    logic [DW-1:0] mem_b [2][8];
    always @(posedge clk) begin
        if (mem_wen)   mem_a[~mem_sw][mem_waddr] <= mem_wdata;
        if (mem_ren)   mem_rdata <= mem_a[mem_sw][mem_raddr];
        if (mem_wen5)  mem_b[~mem_sw5][mem_waddr5] <= mem_wdata5;
        if (mem_ren5)  mem_rdata5 <= mem_b[mem_sw5][mem_raddr5];
    end

    always @(posedge clk) begin
        #1;
        case (out_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream-level model: accepted words queue up and must leave in order; tiles are TILE words;
    // a swap can only follow a completed tile and input stalls only while a full tile waits.
    logic [DW-1:0] sb [$];
    int   acc_cnt = 0, ren_cnt = 0, pop_cnt = 0, tog_cnt = 0;
    logic prev_sw = 1'b0;
    logic exp_ready;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            acc_cnt = 0; ren_cnt = 0; pop_cnt = 0; tog_cnt = 0;
            prev_sw = 1'b0;
        end else begin
            if (mem_sw !== prev_sw) begin
                tog_cnt++;
                prev_sw = mem_sw;
                check("swap_after_full_tile", acc_cnt, tog_cnt * TILE);
            end
            exp_ready = (acc_cnt != TILE * (tog_cnt + 1));
            check("in_ready", in_ready, exp_ready);
            check("mem_wen", mem_wen, in_valid && exp_ready);
            check("fifo_occupancy_le2", (ren_cnt - pop_cnt) <= 2, 1);
            if (mem_wen) begin
                check("mem_waddr", mem_waddr, acc_cnt % TILE);
                check("mem_wdata", mem_wdata, in_data);
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                acc_cnt++;
            end
            if (!out_valid) check("out_last_idle", out_last, 0);
            if (out_valid) check("out_valid_has_source", (ren_cnt - pop_cnt) >= 1, 1);
            if (mem_ren) begin
                check("mem_raddr", mem_raddr, ren_cnt % TILE);
                check("ren_from_swapped_tile", ren_cnt < TILE * tog_cnt, 1);
                ren_cnt++;
            end
            if (out_valid && out_ready) begin
                check("out_has_pending", sb.size() > 0, 1);
                if (sb.size() > 0) check("out_data_order", out_data, sb.pop_front());
                check("out_last", out_last, (pop_cnt % TILE) == TILE - 1);
                pop_cnt++;
            end
        end
    end

    // Same rules for the TILE_LEN=5 instance, whose input stream is 0,1,2,...
    int   acc5 = 0, ren5 = 0, pop5 = 0, tog5 = 0;
    logic prev_sw5 = 1'b0;

    always @(negedge clk) begin
        if (rst5) begin
            acc5 = 0; ren5 = 0; pop5 = 0; tog5 = 0;
            prev_sw5 = 1'b0;
        end else begin
            if (mem_sw5 !== prev_sw5) begin
                tog5++;
                prev_sw5 = mem_sw5;
                check("t5_swap_every5", acc5, tog5 * TILE5);
            end
            check("t5_in_ready", in_ready5, acc5 != TILE5 * (tog5 + 1));
            if (mem_wen5) check("t5_waddr", mem_waddr5, acc5 % TILE5);
            if (in_valid5 && in_ready5) acc5++;
            if (mem_ren5) begin
                check("t5_raddr", mem_raddr5, ren5 % TILE5);
                ren5++;
            end
            if (out_valid5) begin
                check("t5_out_data", out_data5, pop5);
                check("t5_out_last", out_last5, (pop5 % TILE5) == TILE5 - 1);
                pop5++;
            end
        end
    end

    initial begin
        rst5 = 1'b1; in_valid5 = 1'b0; in_data5 = '0;
        repeat (3) @(posedge clk);
        #1 rst5 = 1'b0;
        in_valid5 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (acc5 >= 50) break;
            in_data5 = DW'(acc5);
        end
        in_valid5 = 1'b0;
        for (int i = 0; i < 300 && pop5 < 50; i++) @(negedge clk);
        check("t5_all_out", pop5, 50);
        check("t5_toggles", tog5, 10);
        done5 = 1'b1;
    end

    task automatic send_word(input logic [DW-1:0] d, output int acc_cyc, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        acc_cyc = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ok = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            if (ok) break;
            stalls++;
        end
        check("send_accepted", ok, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic at_cycle(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && !(pop_cnt == acc_cnt && ren_cnt == pop_cnt); i++)
            @(negedge clk);
        check(name, (pop_cnt == acc_cnt) && (ren_cnt == pop_cnt), 1);
        @(posedge clk); #1;
    endtask

    // One tile right after reset with out_ready high: exact cycle positions are pinned here.
    task automatic run_single_tile(input logic [DW-1:0] base);
        int c, st;
        c = 0;
        for (int k = 0; k < TILE; k++) send_word(base + DW'(k), c, st);
        at_cycle(c + 1);
        check("t1_sw_before_swap", mem_sw, 0);
        check("t1_in_ready_full", in_ready, 0);
        at_cycle(c + 2);
        check("t1_sw_rise", mem_sw, 1);
        check("t1_first_ren", mem_ren, 1);
        check("t1_first_raddr", mem_raddr, 0);
        at_cycle(c + 3);
        check("t1_no_early_out", out_valid, 0);
        for (int k = 0; k < TILE; k++) begin
            at_cycle(c + 4 + k);
            check("t1_out_valid", out_valid, 1);
            check("t1_out_data", out_data, base + DW'(k));
            check("t1_out_last", out_last, k == TILE - 1);
        end
        at_cycle(c + 12);
        check("t1_out_done", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int c, st, r0, p0, t0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_sw", mem_sw, 0);
        rst = 1'b0;

        run_single_tile(16'd0);
        drain("s1_drain");

        t0 = tog_cnt; p0 = pop_cnt;
        for (int k = 0; k < 32; k++) begin
            send_word(DW'(1000 + k), c, st);
            check("s2_stall_le1", st <= 1, 1);
        end
        drain("s2_drain");
        check("s2_toggles", tog_cnt - t0, 4);
        check("s2_outputs", pop_cnt - p0, 32);

        out_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        r0 = ren_cnt; p0 = pop_cnt;
        for (int k = 0; k < 2 * TILE; k++) send_word(DW'(2000 + k), c, st);
        for (int j = 0; j < 6; j++) begin
            at_cycle(c + 4 + j);
            check("s3_ren_le2", (ren_cnt - r0) <= 2, 1);
            check("s3_out_valid_held", out_valid, 1);
            check("s3_out_data_held", out_data, 2000);
            check("s3_in_ready_blocked", in_ready, 0);
        end
        out_mode = 1;
        drain("s3_drain");
        check("s3_outputs", pop_cnt - p0, 16);

        out_mode = 2;
        p0 = pop_cnt;
        for (int k = 0; k < 10 * TILE; k++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                @(posedge clk); #1;
            end
            send_word(DW'($urandom), c, st);
        end
        drain("s4_drain");
        check("s4_outputs", pop_cnt - p0, 80);
        out_mode = 1;

        p0 = pop_cnt;
        for (int k = 0; k < 2 * TILE; k++) send_word(DW'(3000 + k), c, st);
        for (int i = 0; i < 200 && (pop_cnt - p0) < 11; i++) @(negedge clk);
        check("s6_reached_mid_tile", (pop_cnt - p0) >= 11, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("s6_out_valid", out_valid, 0);
        check("s6_in_ready", in_ready, 1);
        check("s6_mem_sw", mem_sw, 0);
        check("s6_mem_ren", mem_ren, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_single_tile(16'd100);
        drain("s6_drain");

        for (int i = 0; i < 2000 && !done5; i++) @(posedge clk);
        check("t5_finished", done5, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
